// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA plotting types and constants
package vga_pkg;

    // Plot arbiter states
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Default adapter port widths
    localparam int X_W      = 9;
    localparam int Y_W      = 9;
    localparam int COLOUR_W = 6;

    // Screen geometry
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

endpackage

// File: rtl/vga_rr_picker.sv
// rtl/vga_rr_picker.sv - combinational round-robin requester picker
//
// Picks the first requesting index, searching upward cyclically from last+1.
//   req     in  N      : request vector
//   last    in  IDX_W  : index that won most recently
//   win     out N      : one-hot winner, zero when nothing requests
//   win_idx out IDX_W  : binary index of the winner (0 when nothing requests)
module vga_rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx
);

    logic [IDX_W-1:0] cand;

    // Walk the offsets from furthest to nearest so the nearest requester
    // after 'last' is the one left standing.
    always_comb begin
        win     = '0;
        win_idx = '0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % N);
            if (req[cand]) begin
                win     = N'(1) << cand;
                win_idx = cand;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin owner of the vga_adapter plot port
//
// Engines hold req for a whole drawing job; the granted engine's pixels are
// registered once and forwarded to the adapter.
//   clk, resetn          : clock, synchronous active-low reset
//   req/done/plot_in     : per-engine request level, job-done pulse, pixel strobe
//   x_in/y_in/colour_in  : packed per-engine pixel data, engine i at [i*W +: W]
//   grant                : one-hot grant or zero
//   writeEn/x/y/colour   : adapter plot port (registered)
//   busy                 : grant held or in the dead cycle after it
//   timeout              : one-cycle pulse when the hold watchdog revokes a grant
//   pixel_count          : pixels forwarded in the current/most recent grant
module vga_plot_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int X_W        = vga_pkg::X_W,
    parameter int Y_W        = vga_pkg::Y_W,
    parameter int COLOUR_W   = vga_pkg::COLOUR_W,
    parameter int HOLD_LIMIT = 0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           done,
    input  logic [NUM_REQ-1:0]           plot_in,
    input  logic [NUM_REQ*X_W-1:0]       x_in,
    input  logic [NUM_REQ*Y_W-1:0]       y_in,
    input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         writeEn,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         busy,
    output logic                         timeout,
    output logic [16:0]                  pixel_count
);
    import vga_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [19:0] HOLD_LAST = (HOLD_LIMIT == 0) ? 20'd0 : 20'(HOLD_LIMIT - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     last_q;
    logic [19:0]          hold_q;
    logic [16:0]          count_q;
    logic                 we_q;
    logic                 timeout_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [COLOUR_W-1:0]  colour_q;

    logic [NUM_REQ-1:0]   win;
    logic [IDX_W-1:0]     win_idx;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [COLOUR_W-1:0]  sel_colour;
    logic                 owner_plot;
    logic                 owner_done;
    logic                 owner_req;
    logic                 wd_fire;
    logic                 release_now;

    vga_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req),
        .last    (last_q),
        .win     (win),
        .win_idx (win_idx)
    );

    // Select the owner's pixel lanes
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                sel_x      = x_in[i*X_W +: X_W];
                sel_y      = y_in[i*Y_W +: Y_W];
                sel_colour = colour_in[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign owner_plot  = plot_in[owner_q];
    assign owner_done  = done[owner_q];
    assign owner_req   = req[owner_q];
    assign wd_fire     = (HOLD_LIMIT != 0) && (hold_q == HOLD_LAST);
    assign release_now = owner_done || !owner_req || wd_fire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (|req) state_d = ARB_GRANT;
            ARB_GRANT: if (release_now) state_d = ARB_RELEASE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= LAST_INIT;
            hold_q    <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            timeout_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (|req) begin
                        grant_q <= win;
                        owner_q <= win_idx;
                        last_q  <= win_idx;
                        hold_q  <= '0;
                        count_q <= '0;
                    end
                end
                ARB_GRANT: begin
                    hold_q <= hold_q + 20'd1;
                    // A pixel in the release cycle is still forwarded
                    if (owner_plot) begin
                        we_q     <= 1'b1;
                        x_q      <= sel_x;
                        y_q      <= sel_y;
                        colour_q <= sel_colour;
                        if (count_q != 17'h1FFFF) count_q <= count_q + 17'd1;
                    end
                    if (release_now) begin
                        grant_q   <= '0;
                        timeout_q <= wd_fire;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant       = grant_q;
    assign writeEn     = we_q;
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign busy        = (state_q != ARB_IDLE);
    assign timeout     = timeout_q;
    assign pixel_count = count_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;
    localparam int N  = 3;
    localparam int XW = 9;
    localparam int YW = 9;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [N-1:0] req = '0, done = '0, plot_in = '0;
    logic [N*XW-1:0] x_in = '0;
    logic [N*YW-1:0] y_in = '0;
    logic [N*CW-1:0] colour_in = '0;

    logic [N-1:0] grant, w_grant;
    logic writeEn, w_writeEn, busy, w_busy, timeout, w_timeout;
    logic [XW-1:0] x, w_x;
    logic [YW-1:0] y, w_y;
    logic [CW-1:0] colour, w_colour;
    logic [16:0] pixel_count, w_pixel_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_plot_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .HOLD_LIMIT(0)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
        .writeEn(writeEn), .x(x), .y(y), .colour(colour), .busy(busy),
        .timeout(timeout), .pixel_count(pixel_count));

    vga_plot_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .HOLD_LIMIT(100)) dut_wd (
        .clk(clk), .resetn(resetn), .req(req), .done(done), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(w_grant),
        .writeEn(w_writeEn), .x(w_x), .y(w_y), .colour(w_colour), .busy(w_busy),
        .timeout(w_timeout), .pixel_count(w_pixel_count));

    // Reference model state: who owns the port, dead-cycle pending, last winner
    int m_owner, m_cool, m_last, m_count;
    logic e_we;
    logic [XW-1:0] e_x;
    logic [YW-1:0] e_y;
    logic [CW-1:0] e_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = '0; done = '0; plot_in = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic set_pixel(input int e, input int px, input int py, input int pc);
        x_in[e*XW +: XW] = XW'(px);
        y_in[e*YW +: YW] = YW'(py);
        colour_in[e*CW +: CW] = CW'(pc);
    endtask

    task automatic model_edge();
        e_we = 1'b0;
        if (!resetn) begin
            m_owner = -1; m_cool = 0; m_last = N - 1; m_count = 0;
            e_x = '0; e_y = '0; e_c = '0;
        end else if (m_owner >= 0) begin
            if (plot_in[m_owner]) begin
                e_we = 1'b1;
                e_x = x_in[m_owner*XW +: XW];
                e_y = y_in[m_owner*YW +: YW];
                e_c = colour_in[m_owner*CW +: CW];
                if (m_count < 131071) m_count++;
            end
            if (done[m_owner] || !req[m_owner]) begin
                m_owner = -1;
                m_cool = 1;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (req[i]) begin
                    m_owner = i; m_last = i; m_count = 0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req = '1; plot_in = '1;
        tick();
        n_checks++;
        if (grant !== 3'b000 || writeEn !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: grant=%b we=%b busy=%b to=%b, expected 000 0 0 0", grant, writeEn, busy, timeout);
        end
        n_checks++;
        if (x !== 9'd0 || y !== 9'd0 || colour !== 6'd0 || pixel_count !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_data: x=%0d y=%0d c=%h cnt=%0d, expected all 0", x, y, colour, pixel_count);
        end
        req = '0; plot_in = '0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_basic_grant();
        do_reset();
        req = 3'b011;
        tick();
        n_checks++;
        if (grant !== 3'b001) begin n_fail++; $display("FAIL first_grant: grant=%b expected 001", grant); end
        for (int c = 1; c < 10; c++) tick();
        done = 3'b001;
        tick();
        done = '0;
        n_checks++;
        if (grant !== 3'b000 || busy !== 1'b1) begin
            n_fail++; $display("FAIL release_cycle: grant=%b busy=%b expected 000 1", grant, busy);
        end
        tick();
        n_checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_cycle: grant=%b busy=%b expected 000 0", grant, busy);
        end
        tick();
        n_checks++;
        if (grant !== 3'b010) begin n_fail++; $display("FAIL rr_second_grant: grant=%b expected 010", grant); end
    endtask

    task automatic test_plot_filter();
        // engine 1 holds the grant on entry
        set_pixel(1, 10, 198, 6'h3F);
        set_pixel(2, 5, 5, 6'h15);
        plot_in = 3'b110;
        tick();
        n_checks++;
        if (writeEn !== 1'b1 || x !== 9'd10 || y !== 9'd198 || colour !== 6'h3F || pixel_count !== 17'd1) begin
            n_fail++;
            $display("FAIL owner_pixel: we=%b x=%0d y=%0d c=%h cnt=%0d expected 1 10 198 3f 1", writeEn, x, y, colour, pixel_count);
        end
        plot_in = 3'b100;
        tick();
        n_checks++;
        if (writeEn !== 1'b0 || x !== 9'd10 || y !== 9'd198 || pixel_count !== 17'd1) begin
            n_fail++;
            $display("FAIL foreign_pixel: we=%b x=%0d y=%0d cnt=%0d expected 0 10 198 1", writeEn, x, y, pixel_count);
        end
        plot_in = '0; req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_done_with_plot();
        do_reset();
        req = 3'b011;
        tick();
        done = 3'b010;
        tick();
        done = '0;
        n_checks++;
        if (grant !== 3'b001) begin n_fail++; $display("FAIL foreign_done: grant=%b expected 001", grant); end
        set_pixel(0, 123, 45, 6'h2A);
        plot_in = 3'b001; done = 3'b001;
        tick();
        plot_in = '0; done = '0;
        n_checks++;
        if (writeEn !== 1'b1 || x !== 9'd123 || y !== 9'd45 || colour !== 6'h2A || grant !== 3'b000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_with_plot: we=%b x=%0d y=%0d c=%h grant=%b busy=%b expected 1 123 45 2a 000 1",
                     writeEn, x, y, colour, grant, busy);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_stream();
        do_reset();
        req = 3'b001;
        tick();
        plot_in = 3'b001;
        for (int i = 0; i < 76800; i++) begin
            set_pixel(0, i % 320, i / 320, i % 64);
            tick();
        end
        n_checks++;
        if (writeEn !== 1'b1 || x !== 9'd319 || y !== 9'd239 || colour !== 6'(76799 % 64)) begin
            n_fail++; $display("FAIL stream_last: we=%b x=%0d y=%0d c=%h expected 1 319 239 %h", writeEn, x, y, colour, 6'(76799 % 64));
        end
        plot_in = '0; done = 3'b001;
        tick();
        done = '0;
        n_checks++;
        if (pixel_count !== 17'd76800 || writeEn !== 1'b0 || x !== 9'd319) begin
            n_fail++; $display("FAIL stream_count: cnt=%0d we=%b x=%0d expected 76800 0 319", pixel_count, writeEn, x);
        end
        tick(); tick();
        n_checks++;
        if (grant !== 3'b001 || pixel_count !== 17'd0) begin
            n_fail++; $display("FAIL stream_clear: grant=%b cnt=%0d expected 001 0", grant, pixel_count);
        end
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_watchdog();
        int early;
        early = 0;
        do_reset();
        req = 3'b100;
        tick();
        n_checks++;
        if (w_grant !== 3'b100) begin n_fail++; $display("FAIL wd_grant: grant=%b expected 100", w_grant); end
        req = 3'b101;
        for (int k = 1; k < 100; k++) begin
            tick();
            if (w_timeout !== 1'b0 || w_grant !== 3'b100) early++;
        end
        n_checks++;
        if (early != 0) begin n_fail++; $display("FAIL wd_early: %0d bad cycles before limit, expected 0", early); end
        tick();
        n_checks++;
        if (w_timeout !== 1'b1 || w_grant !== 3'b000) begin
            n_fail++; $display("FAIL wd_fire: timeout=%b grant=%b expected 1 000", w_timeout, w_grant);
        end
        tick();
        n_checks++;
        if (w_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_pulse: timeout=%b expected 0", w_timeout); end
        tick();
        n_checks++;
        if (w_grant !== 3'b001) begin n_fail++; $display("FAIL wd_next_winner: grant=%b expected 001", w_grant); end
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 3'b010;
        tick();
        set_pixel(1, 77, 88, 6'h11);
        plot_in = 3'b010;
        tick();
        resetn = 1'b0;
        tick();
        n_checks++;
        if (grant !== 3'b000 || writeEn !== 1'b0 || busy !== 1'b0 || pixel_count !== 17'd0) begin
            n_fail++;
            $display("FAIL mid_reset: grant=%b we=%b busy=%b cnt=%0d expected 000 0 0 0", grant, writeEn, busy, pixel_count);
        end
        resetn = 1'b1; plot_in = '0; req = 3'b111;
        tick();
        n_checks++;
        if (grant !== 3'b001) begin n_fail++; $display("FAIL post_reset_winner: grant=%b expected 001", grant); end
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic [N-1:0] e_grant;
        resetn = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) resetn = ($urandom_range(0, 299) != 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
                done[b] = ($urandom_range(0, 11) == 0);
            end
            plot_in = N'($urandom);
            x_in = (N*XW)'($urandom);
            y_in = (N*YW)'($urandom);
            colour_in = (N*CW)'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            n_checks++;
            if (grant !== e_grant || busy !== ((m_owner >= 0) || (m_cool != 0)) || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_ctl cyc %0d: grant=%b busy=%b to=%b expected %b %b 0",
                         cyc, grant, busy, timeout, e_grant, (m_owner >= 0) || (m_cool != 0));
            end
            n_checks++;
            if (writeEn !== e_we || x !== e_x || y !== e_y || colour !== e_c || pixel_count !== 17'(m_count)) begin
                n_fail++;
                $display("FAIL rand_pix cyc %0d: we=%b x=%0d y=%0d c=%h cnt=%0d expected %b %0d %0d %h %0d",
                         cyc, writeEn, x, y, colour, pixel_count, e_we, e_x, e_y, e_c, m_count);
            end
        end
        req = '0; done = '0; plot_in = '0;
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_plot_filter();
        test_done_with_plot();
        test_watchdog();
        test_reset_mid_grant();
        test_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
